// File: rtl/bmc_encoder.sv
// Biphase-mark transmitter: frames a bit_considered-wide word (sync '1' + payload MSB first) under an active-low envelope.
// Latency: envelope falls the cycle after acceptance, first edge LEAD_CYCLES later, done/ready closing edge + TAIL_CYCLES.
// Backpressure: single-word valid/ready handshake, no queueing; send while busy or disabled is dropped.
module bmc_encoder #(
    parameter int bit_considered  = 17,
    parameter int HALF_BIT_CYCLES = 8,
    parameter int LEAD_CYCLES     = 4,
    parameter int TAIL_CYCLES     = 15
) (
    input  logic                      clk_96MHz,
    input  logic                      reset_n,
    input  logic                      enabled,
    input  logic [bit_considered-1:0] data_in,
    input  logic                      send,
    output logic                      ready,
    output logic                      d_out,
    output logic                      e_out,
    output logic                      done
);

    localparam int HW   = $clog2(HALF_BIT_CYCLES) + 1;
    localparam int BW   = $clog2(bit_considered + 1);
    localparam int PMAX = (LEAD_CYCLES > TAIL_CYCLES) ? LEAD_CYCLES : TAIL_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);

    localparam logic [HW-1:0] HALF_LOAD = HW'(HALF_BIT_CYCLES - 1);
    localparam logic [PW-1:0] LEAD_LOAD = PW'(LEAD_CYCLES - 1);
    localparam logic [PW-1:0] TAIL_LOAD = PW'(TAIL_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LOAD  = BW'(bit_considered - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_SYNC,
        S_DATA,
        S_TAIL
    } state_t;

    state_t                    state, state_nxt;
    logic [HW-1:0]             hcnt, hcnt_nxt;
    logic                      half2, half2_nxt;
    logic [BW-1:0]             bcnt, bcnt_nxt;
    logic [PW-1:0]             pcnt, pcnt_nxt;
    logic [bit_considered-1:0] shreg, shreg_nxt;
    logic                      ready_nxt, d_nxt, e_nxt, done_nxt;
    logic                      cur_bit;

    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            hcnt  <= '0;
            half2 <= 1'b0;
            bcnt  <= '0;
            pcnt  <= '0;
            shreg <= '0;
            ready <= 1'b1;
            d_out <= 1'b0;
            e_out <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            half2 <= half2_nxt;
            bcnt  <= bcnt_nxt;
            pcnt  <= pcnt_nxt;
            shreg <= shreg_nxt;
            ready <= ready_nxt;
            d_out <= d_nxt;
            e_out <= e_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        half2_nxt = half2;
        bcnt_nxt  = bcnt;
        pcnt_nxt  = pcnt;
        shreg_nxt = shreg;
        ready_nxt = ready;
        d_nxt     = d_out;
        e_nxt     = e_out;
        done_nxt  = 1'b0;
        cur_bit   = (state == S_SYNC) ? 1'b1 : shreg[bit_considered-1];

        // Abort has priority over any edge due this cycle: the line level freezes.
        if (state != S_IDLE && !enabled) begin
            state_nxt = S_IDLE;
            e_nxt     = 1'b1;
            ready_nxt = 1'b1;
            hcnt_nxt  = '0;
            half2_nxt = 1'b0;
            bcnt_nxt  = '0;
            pcnt_nxt  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (send && ready && enabled) begin
                        shreg_nxt = data_in;
                        state_nxt = S_LEAD;
                        pcnt_nxt  = LEAD_LOAD;
                        e_nxt     = 1'b0;
                        ready_nxt = 1'b0;
                    end
                end
                S_LEAD: begin
                    if (pcnt == '0) begin
                        d_nxt     = ~d_out;
                        state_nxt = S_SYNC;
                        hcnt_nxt  = HALF_LOAD;
                        half2_nxt = 1'b0;
                    end else begin
                        pcnt_nxt = pcnt - 1'b1;
                    end
                end
                S_SYNC, S_DATA: begin
                    if (hcnt != '0) begin
                        hcnt_nxt = hcnt - 1'b1;
                    end else begin
                        hcnt_nxt = HALF_LOAD;
                        if (!half2) begin
                            half2_nxt = 1'b1;
                            if (cur_bit) begin
                                d_nxt = ~d_out;
                            end
                        end else begin
                            // Bit boundary: the toggle here starts the next bit or closes the frame.
                            half2_nxt = 1'b0;
                            d_nxt     = ~d_out;
                            if (state == S_SYNC) begin
                                state_nxt = S_DATA;
                                bcnt_nxt  = BIT_LOAD;
                            end else if (bcnt == '0) begin
                                state_nxt = S_TAIL;
                                pcnt_nxt  = TAIL_LOAD;
                                hcnt_nxt  = '0;
                            end else begin
                                bcnt_nxt  = bcnt - 1'b1;
                                shreg_nxt = shreg << 1;
                            end
                        end
                    end
                end
                S_TAIL: begin
                    if (pcnt == '0) begin
                        state_nxt = S_IDLE;
                        e_nxt     = 1'b1;
                        done_nxt  = 1'b1;
                        ready_nxt = 1'b1;
                    end else begin
                        pcnt_nxt = pcnt - 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bmc_encoder.sv
// Scoreboard bench for bmc_encoder: driver pushes expected frames, a line monitor decodes d_out/e_out and compares.
module tb_bmc_encoder;

    localparam int N     = 17;
    localparam int HB    = 8;
    localparam int LEAD  = 4;
    localparam int TAIL  = 15;
    localparam int FIRST = 1 + LEAD;
    localparam int CLOSE = FIRST + (N + 1) * 2 * HB;
    localparam int DONEC = CLOSE + TAIL;

    logic         clk_96MHz = 1'b0;
    logic         reset_n;
    logic         enabled;
    logic [N-1:0] data_in;
    logic         send;
    logic         ready, d_out, e_out, done;

    bmc_encoder #(
        .bit_considered (N),
        .HALF_BIT_CYCLES(HB),
        .LEAD_CYCLES    (LEAD),
        .TAIL_CYCLES    (TAIL)
    ) dut (
        .clk_96MHz(clk_96MHz),
        .reset_n  (reset_n),
        .enabled  (enabled),
        .data_in  (data_in),
        .send     (send),
        .ready    (ready),
        .d_out    (d_out),
        .e_out    (e_out),
        .done     (done)
    );

    initial forever #5 clk_96MHz = ~clk_96MHz;

    typedef struct {
        logic [N-1:0] word;
        int           acc;
        int           abort_at;
        int           gap;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk_96MHz) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_edges(input logic [N-1:0] w, input int lim);
        int   c;
        logic b;
        c = 0;
        for (int k = 0; k <= N; k++) begin
            b = (k == 0) ? 1'b1 : w[N-k];
            if (FIRST + 2*HB*k <= lim) c++;
            if (b && (FIRST + 2*HB*k + HB <= lim)) c++;
        end
        if (CLOSE <= lim) c++;
        return c;
    endfunction

    // Line monitor
    logic         prev_d = 1'b0, prev_e = 1'b1, prev_done = 1'b0;
    logic         active = 1'b0;
    logic         edge_at [0:511];
    logic [N-1:0] dec;
    int           t0, rel, nedge, first_edge, last_edge, hi_len = 0, fall_gap = 0, stray = 0, starts;
    exp_t         e;

    always @(negedge clk_96MHz) begin
        if (!reset_n) begin
            active = 1'b0;
        end else begin
            rel = cyc - t0 + 1;
            if (prev_done) chk("done_pulse", done, 0);
            if (done) chk("done_w_env_rise", e_out && !prev_e, 1);
            if (prev_e && !e_out) begin
                active     = 1'b1;
                t0         = cyc;
                rel        = 1;
                fall_gap   = hi_len;
                hi_len     = 0;
                nedge      = 0;
                first_edge = 0;
                last_edge  = 0;
                for (int i = 0; i < 512; i++) edge_at[i] = 1'b0;
            end else if (e_out) begin
                hi_len++;
            end
            if (d_out !== prev_d) begin
                if (active) begin
                    nedge++;
                    if (nedge == 1) first_edge = rel;
                    last_edge = rel;
                    if (rel < 512) edge_at[rel] = 1'b1;
                end else begin
                    stray++;
                end
            end
            if (!prev_e && e_out && active) begin
                active = 1'b0;
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("env_fall_cyc", t0, e.acc);
                    if (e.gap != 0) chk("env_gap", fall_gap, e.gap);
                    if (e.abort_at != 0) begin
                        chk("abort_cyc", rel, e.abort_at);
                        chk("abort_no_done", done, 0);
                        chk("abort_ready", ready, 1);
                        chk("abort_edges", nedge, model_edges(e.word, e.abort_at - 1));
                    end else begin
                        dec    = '0;
                        starts = 0;
                        for (int k = 0; k <= N + 1; k++) if (edge_at[FIRST + 2*HB*k]) starts++;
                        for (int k = 1; k <= N; k++) dec[N-k] = edge_at[FIRST + 2*HB*k + HB];
                        chk("done_cyc", rel, DONEC);
                        chk("done_set", done, 1);
                        chk("ready_set", ready, 1);
                        chk("edge_count", nedge, model_edges(e.word, CLOSE));
                        chk("first_edge", first_edge, FIRST);
                        chk("close_edge", last_edge, CLOSE);
                        chk("bit_starts", starts, N + 2);
                        chk("sync_mid", edge_at[FIRST + HB], 1);
                        chk("word", dec, e.word);
                    end
                end
            end
        end
        prev_d    = d_out;
        prev_e    = e_out;
        prev_done = done;
    end

    task automatic accept(input logic [N-1:0] w, output int acc);
        int n;
        n = 0;
        @(negedge clk_96MHz);
        while (!ready && n < 2000) begin
            @(negedge clk_96MHz);
            n++;
        end
        chk("ready_wait", ready, 1);
        data_in = w;
        send    = 1'b1;
        @(negedge clk_96MHz);
        send = 1'b0;
        acc  = cyc;
    endtask

    task automatic send_word(input logic [N-1:0] w, input int abort_at);
        int acc;
        accept(w, acc);
        sb.push_back('{w, acc, abort_at, 0});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk_96MHz);
            n++;
        end
        chk("drain", sb.size(), 0);
        repeat (3) @(negedge clk_96MHz);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int           acc, n;
        logic [N-1:0] w;
        reset_n = 1'b0;
        enabled = 1'b1;
        send    = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk_96MHz);
        reset_n = 1'b1;
        @(negedge clk_96MHz);
        chk("rst_ready", ready, 1);
        chk("rst_d", d_out, 0);
        chk("rst_e", e_out, 1);
        chk("rst_done", done, 0);

        send_word(17'h17274, 0);
        drain();
        send_word(17'h00000, 0);
        drain();
        send_word(17'h1FFFF, 0);
        drain();

        // send while busy with other data is dropped
        send_word(17'h0A5A5, 0);
        repeat (40) @(negedge clk_96MHz);
        data_in = 17'h1F0F0;
        send    = 1'b1;
        repeat (3) @(negedge clk_96MHz);
        send = 1'b0;
        drain();

        // back-to-back with send held high
        send_word(17'h12345, 0);
        data_in = 17'h0BEEF;
        send    = 1'b1;
        n = 0;
        while (!ready && n < 2000) begin
            @(negedge clk_96MHz);
            n++;
        end
        chk("b2b_ready", ready, 1);
        @(negedge clk_96MHz);
        send = 1'b0;
        sb.push_back('{17'h0BEEF, cyc, 0, 1});
        drain();

        // disabled in IDLE: requests ignored
        enabled = 1'b0;
        data_in = 17'h13579;
        send    = 1'b1;
        repeat (6) begin
            @(negedge clk_96MHz);
            chk("inhibit_ready", ready, 1);
            chk("inhibit_env", e_out, 1);
        end
        send    = 1'b0;
        enabled = 1'b1;

        // abort: enabled low during cycle 100
        send_word(17'h17274, 101);
        repeat (99) @(negedge clk_96MHz);
        enabled = 1'b0;
        @(negedge clk_96MHz);
        enabled = 1'b1;
        drain();
        send_word(17'h15555, 0);
        drain();

        // async reset mid-DATA
        accept(17'h1ABCD, acc);
        repeat (150) @(negedge clk_96MHz);
        @(posedge clk_96MHz);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_ready", ready, 1);
        chk("arst_d", d_out, 0);
        chk("arst_e", e_out, 1);
        chk("arst_done", done, 0);
        repeat (2) @(negedge clk_96MHz);
        #2;
        reset_n = 1'b1;
        send_word(17'h0C3C3, 0);
        drain();

        for (int i = 0; i < 3; i++) begin
            w = N'($urandom());
            send_word(w, 0);
            drain();
        end

        repeat (20) @(negedge clk_96MHz);
        chk("stray_edges", stray, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
